// File: rtl/dti_sink.sv
// rtl/dti_sink.sv - DTI consumer endpoint: backpressure generator, show-ahead capture FIFO, counters.
// Optional valid/data hold check enabled by defining DTI_SINK_HOLD_CHECK_EN.
module dti_sink #(
   parameter int unsigned W_DATA    = 16,
   parameter int unsigned DEPTH     = 8,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int unsigned W_CNT     = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [W_DATA-1:0]         din_data,
   input  logic                      din_valid,
   output logic                      din_ready,
   input  logic [1:0]                cfg_mode,
   input  logic [7:0]                cfg_on,
   input  logic [7:0]                cfg_off,
   input  logic [7:0]                cfg_thresh,
   input  logic                      rd_en,
   output logic [W_DATA-1:0]         rd_data,
   output logic                      rd_empty,
   output logic [$clog2(DEPTH):0]    fill,
   input  logic                      cnt_clr,
   output logic [W_CNT-1:0]          xfer_cnt,
   output logic [W_CNT-1:0]          stall_cnt,
   output logic                      err_hold
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

   localparam logic [1:0] MODE_ALWAYS   = 2'd0;
   localparam logic [1:0] MODE_NEVER    = 2'd1;
   localparam logic [1:0] MODE_PERIODIC = 2'd2;
   localparam logic [1:0] MODE_RANDOM   = 2'd3;

   typedef enum logic {PH_ON, PH_OFF} phase_e;

   logic [W_DATA-1:0] mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW:0]       fill_q, fill_d;
   logic              ready_q, ready_d;
   logic [15:0]       lfsr_q, lfsr_d;
   phase_e            phase_q, phase_d;
   logic [7:0]        pcnt_q, pcnt_d;
   logic [W_CNT-1:0]  xfer_q, xfer_d;
   logic [W_CNT-1:0]  stall_q, stall_d;
   logic              push, pop, allow;

   assign push = din_valid & ready_q;
   assign pop  = rd_en & (fill_q != '0);

   assign din_ready = ready_q;
   assign rd_data   = mem_q[rd_ptr_q];
   assign rd_empty  = (fill_q == '0);
   assign fill      = fill_q;
   assign xfer_cnt  = xfer_q;
   assign stall_cnt = stall_q;

   always_comb begin
      wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
      fill_d   = fill_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
   end

   // x^16+x^14+x^13+x^11+1, shifting right; steps every cycle regardless of mode
   assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

   // Periodic phase FSM: phase_q is the phase of the ready value being registered now
   always_comb begin
      phase_d = phase_q;
      pcnt_d  = pcnt_q;
      if (cfg_mode != MODE_PERIODIC) begin
         phase_d = PH_ON;
         pcnt_d  = '0;
      end else if (phase_q == PH_ON) begin
         if (({1'b0, pcnt_q} + 9'd1) >= {1'b0, cfg_on}) begin
            pcnt_d  = '0;
            phase_d = (cfg_off == 8'd0) ? PH_ON : PH_OFF;
         end else begin
            pcnt_d = pcnt_q + 8'd1;
         end
      end else begin
         if (({1'b0, pcnt_q} + 9'd1) >= {1'b0, cfg_off}) begin
            pcnt_d  = '0;
            phase_d = PH_ON;
         end else begin
            pcnt_d = pcnt_q + 8'd1;
         end
      end
   end

   always_comb begin
      allow = 1'b0;
      case (cfg_mode)
         MODE_ALWAYS:   allow = 1'b1;
         MODE_NEVER:    allow = 1'b0;
         MODE_PERIODIC: allow = (phase_q == PH_ON) && (cfg_on != 8'd0);
         MODE_RANDOM:   allow = (lfsr_d[7:0] < cfg_thresh);
         default:       allow = 1'b0;
      endcase
      // Gating on next occupancy keeps the FIFO from ever overflowing
      ready_d = allow && (fill_d < DEPTH_W);
   end

   always_comb begin
      xfer_d  = xfer_q;
      stall_d = stall_q;
      if (cnt_clr) begin
         xfer_d  = '0;
         stall_d = '0;
      end else begin
         if (push && (xfer_q != '1)) begin
            xfer_d = xfer_q + W_CNT'(1);
         end
         if (din_valid && !ready_q && (stall_q != '1)) begin
            stall_d = stall_q + W_CNT'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
         ready_q  <= 1'b0;
         lfsr_q   <= LFSR_SEED;
         phase_q  <= PH_ON;
         pcnt_q   <= '0;
         xfer_q   <= '0;
         stall_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
         ready_q  <= ready_d;
         lfsr_q   <= lfsr_d;
         phase_q  <= phase_d;
         pcnt_q   <= pcnt_d;
         xfer_q   <= xfer_d;
         stall_q  <= stall_d;
      end
   end

`ifdef DTI_SINK_HOLD_CHECK_EN
   logic              pend_q;
   logic [W_DATA-1:0] prev_data_q;
   logic              err_q, err_d;

   // A stalled offer must be repeated unchanged on the following cycle
   always_comb begin
      err_d = err_q | (pend_q & (!din_valid | (din_data != prev_data_q)));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_q      <= 1'b0;
         prev_data_q <= '0;
         err_q       <= 1'b0;
      end else begin
         pend_q      <= din_valid & !ready_q;
         prev_data_q <= din_data;
         err_q       <= err_d;
      end
   end

   assign err_hold = err_q;
`else
   assign err_hold = 1'b0;
`endif

endmodule

// File: tb/tb_dti_sink.sv
// tb/tb_dti_sink.sv - Scoreboard bench for dti_sink against a cycle-level behavioural model.
module tb_dti_sink;
   localparam int W_DATA = 16;
   localparam int DEPTH  = 8;
   localparam int W_CNT  = 32;
   localparam logic [15:0] SEED = 16'hACE1;
`ifdef DTI_SINK_HOLD_CHECK_EN
   localparam bit HOLD_EN = 1'b1;
`else
   localparam bit HOLD_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst;
   logic [W_DATA-1:0] din_data;
   logic              din_valid;
   logic              din_ready;
   logic [1:0]        cfg_mode;
   logic [7:0]        cfg_on, cfg_off, cfg_thresh;
   logic              rd_en;
   logic [W_DATA-1:0] rd_data;
   logic              rd_empty;
   logic [3:0]        fill;
   logic              cnt_clr;
   logic [W_CNT-1:0]  xfer_cnt, stall_cnt;
   logic              err_hold;

   dti_sink #(.W_DATA(W_DATA), .DEPTH(DEPTH), .LFSR_SEED(SEED), .W_CNT(W_CNT)) dut (
      .clk(clk), .rst(rst), .din_data(din_data), .din_valid(din_valid), .din_ready(din_ready),
      .cfg_mode(cfg_mode), .cfg_on(cfg_on), .cfg_off(cfg_off), .cfg_thresh(cfg_thresh),
      .rd_en(rd_en), .rd_data(rd_data), .rd_empty(rd_empty), .fill(fill),
      .cnt_clr(cnt_clr), .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt), .err_hold(err_hold)
   );

   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;

   logic [W_DATA-1:0] exp_q[$];
   logic [W_DATA-1:0] src_q[$];
   bit                send_en;
   bit                manual;

   bit                m_ready;
   int                m_fill;
   logic [W_CNT-1:0]  m_xfer, m_stall;
   bit                m_err;
   logic [15:0]       m_lfsr;
   int                m_pt;
   bit                m_prev_pend;
   logic [W_DATA-1:0] m_prev_data;

   bit tr [2][1000];
   int duty [2];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_adv(input logic [15:0] s);
      return {^(s & 16'h002D), s[15:1]};
   endfunction

   // Behavioural reference for one clock edge, using the inputs currently applied
   task automatic model_edge();
      bit push, pop, stall, allow;
      int period;
      if (rst) begin
         m_ready = 0; m_fill = 0; exp_q.delete();
         m_xfer = '0; m_stall = '0; m_err = 0;
         m_lfsr = SEED; m_pt = 0; m_prev_pend = 0; m_prev_data = '0;
         return;
      end
      push  = din_valid && m_ready;
      pop   = rd_en && (m_fill > 0);
      stall = din_valid && !m_ready;
      if (push) begin
         exp_q.push_back(din_data);
         if (!manual) void'(src_q.pop_front());
      end
      if (HOLD_EN && m_prev_pend && (!din_valid || din_data != m_prev_data)) m_err = 1;
      m_prev_pend = stall;
      m_prev_data = din_data;
      if (cnt_clr) begin
         m_xfer = '0; m_stall = '0;
      end else begin
         if (push && m_xfer != '1) m_xfer++;
         if (stall && m_stall != '1) m_stall++;
      end
      m_fill = m_fill + int'(push) - int'(pop);
      m_lfsr = lfsr_adv(m_lfsr);
      allow = 0;
      if (cfg_mode == 2'd0) allow = 1;
      else if (cfg_mode == 2'd3) allow = (m_lfsr[7:0] < cfg_thresh);
      if (cfg_mode == 2'd2) begin
         period = int'(cfg_on) + int'(cfg_off);
         allow = (cfg_on != 0) && ((cfg_off == 0) || ((m_pt % period) < int'(cfg_on)));
         m_pt++;
      end else begin
         m_pt = 0;
      end
      m_ready = allow && (m_fill < DEPTH);
   endtask

   task automatic step();
      if (!manual) begin
         din_valid = send_en && (src_q.size() > 0);
         din_data  = (src_q.size() > 0) ? src_q[0] : '0;
      end
      model_edge();
      @(posedge clk);
      #1;
      chk("din_ready", din_ready, m_ready);
      chk("fill", fill, m_fill);
      chk("rd_empty", rd_empty, m_fill == 0);
      chk("xfer_cnt", xfer_cnt, m_xfer);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("err_hold", err_hold, m_err);
   endtask

   task automatic drain();
      bit done = 0;
      cfg_mode = 2'd0; rd_en = 1; send_en = 1; cnt_clr = 0;
      for (int k = 0; k < 200; k++) begin
         if (src_q.size() == 0 && m_fill == 0) begin
            done = 1;
            break;
         end
         step();
      end
      if (!done) begin
         n_total++; n_bad++;
         $display("FAIL drain: not empty after 200 cycles, model fill %0d", m_fill);
      end
   endtask

   task automatic rand_run(input int run);
      rst = 1; manual = 0; send_en = 0; step(); rst = 0;
      cfg_mode = 2'd3; cfg_thresh = 8'd0; rd_en = 1; send_en = 1; cnt_clr = 0;
      for (int i = 0; i < 100; i++) begin
         if (src_q.size() < 2) src_q.push_back(16'(i));
         step();
      end
      chk("rand_thresh0_xfer", xfer_cnt, 0);
      cfg_thresh = 8'h80;
      duty[run] = 0;
      for (int i = 0; i < 1000; i++) begin
         if (src_q.size() < 2) src_q.push_back(16'(i + 7));
         step();
         tr[run][i] = din_ready;
         if (din_ready) duty[run]++;
      end
   endtask

   // Scoreboard monitor: every DUT pop is checked against the oldest accepted word
   always @(negedge clk) begin
      if (!rst && rd_en && !rd_empty) begin
         if (exp_q.size() == 0) begin
            n_total++; n_bad++;
            $display("FAIL rd_data: pop with nothing expected, got %0h", rd_data);
         end else begin
            chk("rd_data", rd_data, exp_q.pop_front());
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int d;
      rst = 1; cfg_mode = 0; cfg_on = 0; cfg_off = 0; cfg_thresh = 0;
      rd_en = 0; cnt_clr = 0; din_valid = 0; din_data = '0; send_en = 0; manual = 0;
      step(); step();
      chk("rst_ready", din_ready, 0);
      chk("rst_fill", fill, 0);
      chk("rst_empty", rd_empty, 1);
      chk("rst_xfer", xfer_cnt, 0);
      chk("rst_stall", stall_cnt, 0);
      chk("rst_err", err_hold, 0);

      // ALWAYS, five words with continuous pops
      rst = 0; cfg_mode = 2'd0; rd_en = 1; step();
      for (int i = 1; i <= 5; i++) src_q.push_back(16'(i));
      send_en = 1;
      for (int i = 0; i < 8; i++) step();
      chk("p1_xfer", xfer_cnt, 5);
      chk("p1_stall", stall_cnt, 0);
      chk("p1_fill", fill, 0);

      // ALWAYS, no pops, 12 words offered
      cnt_clr = 1; send_en = 0; step(); cnt_clr = 0;
      rd_en = 0;
      for (int i = 0; i < 12; i++) src_q.push_back(16'h0100 + 16'(i));
      send_en = 1;
      for (int i = 0; i < 14; i++) step();
      chk("p2_full_fill", fill, 8);
      chk("p2_full_ready", din_ready, 0);
      chk("p2_full_xfer", xfer_cnt, 8);
      chk("p2_full_stall", stall_cnt, 6);
      rd_en = 1; step(); rd_en = 0;
      chk("p2_pop_ready", din_ready, 1);
      chk("p2_pop_fill", fill, 7);
      for (int i = 0; i < 4; i++) step();
      chk("p2_one_more_xfer", xfer_cnt, 9);
      chk("p2_one_more_fill", fill, 8);
      chk("p2_one_more_stall", stall_cnt, 10);
      drain();

      // PERIODIC on=3 off=2
      cfg_mode = 2'd2; cfg_on = 8'd3; cfg_off = 8'd2; cnt_clr = 1; send_en = 0; rd_en = 1; step();
      cnt_clr = 0;
      for (int i = 0; i < 30; i++) src_q.push_back(16'h0200 + 16'(i));
      send_en = 1;
      for (int i = 0; i < 20; i++) begin
         chk("p3_ready_pattern", din_ready, (i % 5) < 3);
         step();
      end
      chk("p3_xfer", xfer_cnt, 12);
      chk("p3_stall", stall_cnt, 8);
      send_en = 0; src_q.delete();
      drain();

      // RANDOM, repeated twice from reset for determinism
      rand_run(0);
      n_total++;
      if (duty[0] < 400 || duty[0] > 600) begin
         n_bad++;
         $display("FAIL rand_duty: got %0d ready cycles of 1000, required 400..600", duty[0]);
      end
      rand_run(1);
      d = 0;
      for (int i = 0; i < 1000; i++) if (tr[0][i] != tr[1][i]) d++;
      chk("rand_repeat_diffs", d, 0);

      // cnt_clr with a same-cycle push, then reset with fill=4
      rst = 1; send_en = 0; step(); rst = 0;
      src_q.delete();
      cfg_mode = 2'd0; rd_en = 1; send_en = 1;
      for (int i = 0; i < 10; i++) src_q.push_back(16'h0300 + 16'(i));
      for (int i = 0; i < 4; i++) step();
      cnt_clr = 1; step(); cnt_clr = 0;
      chk("p5_clr_xfer", xfer_cnt, 0);
      step();
      chk("p5_after_clr_xfer", xfer_cnt, 1);
      send_en = 0; src_q.delete();
      drain();
      rd_en = 0;
      for (int i = 0; i < 4; i++) src_q.push_back(16'h0400 + 16'(i));
      send_en = 1;
      for (int i = 0; i < 6; i++) step();
      chk("p5_fill4", fill, 4);
      send_en = 0; rst = 1; step(); rst = 0;
      chk("p5_rst_fill", fill, 0);
      chk("p5_rst_empty", rd_empty, 1);
      chk("p5_rst_ready", din_ready, 0);

      // NEVER, producer drops valid after one stalled cycle
      cfg_mode = 2'd1; step();
      manual = 1; din_valid = 1; din_data = 16'h0055; step();
      din_valid = 0; step();
      chk("p6_err_set", err_hold, HOLD_EN);
      for (int i = 0; i < 3; i++) step();
      chk("p6_err_sticky", err_hold, HOLD_EN);
      cnt_clr = 1; step(); cnt_clr = 0;
      chk("p6_err_cnt_clr", err_hold, HOLD_EN);
      rst = 1; step(); rst = 0;
      chk("p6_err_rst", err_hold, 0);
      manual = 0;

      // Randomized segments across all modes
      for (int seg = 0; seg < 10; seg++) begin
         cfg_mode = 2'd0; send_en = 1; cnt_clr = 0; step();
         cfg_mode   = 2'($urandom_range(0, 3));
         cfg_on     = 8'($urandom_range(0, 5));
         cfg_off    = 8'($urandom_range(0, 4));
         cfg_thresh = 8'($urandom_range(0, 255));
         for (int i = 0; i < 40; i++) begin
            rd_en   = ($urandom_range(0, 99) < 60);
            cnt_clr = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 1) == 1) src_q.push_back(16'($urandom));
            step();
         end
      end
      cnt_clr = 0;
      drain();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

// File: doc/dti_sink.md
Name: dti_sink

Overview:
- Synthesizable DTI consumer endpoint: accepts valid/ready/data transfers from any DTI producer under test.
- Drives ready from a configurable backpressure generator: always, never, periodic or pseudo-random.
- Captures accepted data into a show-ahead FIFO drained by the bench or a scoreboard.
- Counts transfers and stall cycles; used in DPI co-simulation and as a standalone RTL load on producer outputs.

Parameters:
- W_DATA, 16, width of din_data and rd_data.
- DEPTH, 8, capture FIFO depth; power of 2, >= 2.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- W_CNT, 32, width of xfer_cnt and stall_cnt.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- din_data  in  W_DATA  producer data.
- din_valid  in  1  producer valid.
- din_ready  out  1  consumer ready; driven directly from a flop.
- cfg_mode  in  2  ready mode: 0 ALWAYS, 1 NEVER, 2 PERIODIC, 3 RANDOM.
- cfg_on  in  8  PERIODIC: number of ready-high cycles.
- cfg_off  in  8  PERIODIC: number of ready-low cycles.
- cfg_thresh  in  8  RANDOM: ready allowed when lfsr[7:0] < cfg_thresh.
- rd_en  in  1  FIFO pop request.
- rd_data  out  W_DATA  FIFO head (show-ahead).
- rd_empty  out  1  FIFO empty.
- fill  out  $clog2(DEPTH)+1  FIFO occupancy.
- cnt_clr  in  1  synchronous clear of both counters.
- xfer_cnt  out  W_CNT  accepted transfers, saturating.
- stall_cnt  out  W_CNT  cycles with din_valid & !din_ready, saturating.
- err_hold  out  1  sticky protocol error (see Optional Feature).

Behaviour:
- Reset values:
  - din_ready=0, fill=0, rd_empty=1, rd_data don't-care.
  - xfer_cnt=0, stall_cnt=0, err_hold=0.
  - lfsr=LFSR_SEED; periodic phase=ON with phase counter=0.
- Handshake: push = din_valid & din_ready. Data is written to the FIFO tail in the same cycle, visible on rd_data no earlier than the next cycle.
- Pop: pop = rd_en & !rd_empty. rd_en while empty is ignored with no state change. Push and pop in one cycle leave fill unchanged.
- fill_next = fill + push - pop.
- din_ready_next = allow_next & (fill_next < DEPTH). This makes overflow impossible by construction.
- allow_next per mode:
  - ALWAYS: 1.
  - NEVER: 0.
  - PERIODIC: 1 in ON phase, 0 in OFF phase.
  - RANDOM: lfsr_next[7:0] < cfg_thresh.
- PERIODIC phase FSM:
  - ON counts cfg_on cycles, then moves to OFF.
  - OFF counts cfg_off cycles, then moves to ON.
  - cfg_on=0: permanently OFF. cfg_off=0 with cfg_on>0: permanently ON.
  - The FSM restarts at ON, count 0, on any cycle where cfg_mode != PERIODIC.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Advances every cycle in every mode.
  - cfg_thresh=0 means never ready; 8'hFF means ready 255 of 256 states.
- Mode change takes effect on the din_ready value registered at the same edge: one-cycle latency from cfg_* to din_ready.
- Ready is independent of din_valid; the sink may present ready with no valid pending.
- Counters:
  - xfer_cnt increments on push; stall_cnt increments on din_valid & !din_ready.
  - Both saturate at all-ones.
  - cnt_clr forces 0 and has priority over a same-cycle increment.
- Reset mid-transfer: the FIFO is flushed and ready drops on the next edge. A producer holding valid simply stalls.

Optional Feature:
- Macro: DTI_SINK_HOLD_CHECK_EN.
- Defined:
  - Registers prev_pending = din_valid & !din_ready and prev_data.
  - If prev_pending and in the current cycle (!din_valid or din_data != prev_data), err_hold is set.
  - err_hold is sticky; it clears only on rst (cnt_clr does not affect it).
- Undefined: no check logic is generated and err_hold is tied to 0.

Test Plan:
- ALWAYS mode, producer sends 0x0001..0x0005 on consecutive cycles, bench pops every cycle -> five pushes, rd_data sequence 1..5, xfer_cnt=5, stall_cnt=0.
- ALWAYS mode, no pops, producer offers 12 words -> din_ready low once fill=8, fill holds at 8, stall_cnt counts stalled cycles; a single pop re-enables exactly one further push two cycles later.
- PERIODIC cfg_on=3 cfg_off=2, valid held high, continuous pops -> din_ready pattern 1,1,1,0,0 repeating; xfer_cnt=12 and stall_cnt=8 after 20 cycles.
- RANDOM, cfg_thresh=0 then 8'h80 -> no pushes over 100 cycles; then a ready duty within 40-60% over 1000 cycles, and a bit-identical ready trace across two runs with the same seed.
- cnt_clr asserted in the same cycle as a push, and rst asserted with fill=4 -> xfer_cnt=0 after the clear; after reset fill=0, rd_empty=1, din_ready=0.
- With DTI_SINK_HOLD_CHECK_EN, NEVER mode, producer drops valid after one stalled cycle -> err_hold=1 the following cycle and stays high until rst; with the macro undefined, err_hold=0.
